// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for the execute stage.
// Accepts DIV/DIVU, stalls the pipeline until the {remainder, quotient}
// result is ready, honours annul, and short-cuts divide-by-zero.
//
// state  | meaning
// -------+---------------------------------------------------------
// FREE   | idle, waiting for start_i
// BYZERO | divisor was zero; clear the working register
// ON     | iterating (cnt 0..31), sign fix when cnt reaches 32
// END    | result presented; hold until start_i drops
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic        stallreq_o,
    output logic        ready_o,
    output logic [63:0] result_o
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic [64:0] dividend, dividend_nxt;
    logic [31:0] divisor, divisor_nxt;
    logic        sgn, sgn_nxt;
    logic        s1, s1_nxt;
    logic        s2, s2_nxt;
    logic        ready_nxt;
    logic [63:0] result_nxt;

    logic [32:0] diff;
    logic [31:0] op1_mag, op2_mag;
    logic [31:0] q_fix, r_fix;

    // Magnitudes and the trial subtraction; the sign fix works on the
    // quotient in [31:0] and the remainder in [64:33].
    assign op1_mag = (signed_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
    assign op2_mag = (signed_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;
    assign diff    = dividend[64:32] - {1'b0, divisor};
    assign q_fix   = (sgn && (s1 ^ s2)) ? (32'd0 - dividend[31:0])  : dividend[31:0];
    assign r_fix   = (sgn && s1)        ? (32'd0 - dividend[64:33]) : dividend[64:33];

    // Stall EX while a request is outstanding and no result is up yet.
    assign stallreq_o = start_i & ~ready_o & ~annul_i;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FREE;
        else      state <= state_nxt;
    end

    // Next-state and datapath update decisions.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        dividend_nxt = dividend;
        divisor_nxt  = divisor;
        sgn_nxt      = sgn;
        s1_nxt       = s1;
        s2_nxt       = s2;
        ready_nxt    = ready_o;
        result_nxt   = result_o;
        unique case (state)
            S_FREE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_nxt = S_BYZERO;
                    end else begin
                        state_nxt    = S_ON;
                        cnt_nxt      = 6'd0;
                        dividend_nxt = {32'd0, op1_mag, 1'b0};
                        divisor_nxt  = op2_mag;
                        sgn_nxt      = signed_i;
                        s1_nxt       = opdata1_i[31];
                        s2_nxt       = opdata2_i[31];
                    end
                end
            end
            S_BYZERO: begin
                dividend_nxt = 65'd0;
                if (annul_i) begin
                    state_nxt = S_FREE;
                end else begin
                    state_nxt  = S_END;
                    ready_nxt  = 1'b1;
                    result_nxt = 64'd0;
                end
            end
            S_ON: begin
                if (annul_i) begin
                    state_nxt = S_FREE;
                end else if (cnt != 6'd32) begin
                    if (diff[32]) dividend_nxt = {dividend[63:0], 1'b0};
                    else          dividend_nxt = {diff[31:0], dividend[31:0], 1'b1};
                    cnt_nxt = cnt + 6'd1;
                end else begin
                    // Result is registered on the same edge the sign fix lands.
                    dividend_nxt = {r_fix, 1'b0, q_fix};
                    result_nxt   = {r_fix, q_fix};
                    ready_nxt    = 1'b1;
                    state_nxt    = S_END;
                end
            end
            S_END: begin
                if (!start_i) begin
                    state_nxt  = S_FREE;
                    ready_nxt  = 1'b0;
                    result_nxt = 64'd0;
                end
            end
            default: state_nxt = S_FREE;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 6'd0;
            dividend <= 65'd0;
            divisor  <= 32'd0;
            sgn      <= 1'b0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
        end else begin
            cnt      <= cnt_nxt;
            dividend <= dividend_nxt;
            divisor  <= divisor_nxt;
            sgn      <= sgn_nxt;
            s1       <= s1_nxt;
            s2       <= s2_nxt;
            ready_o  <= ready_nxt;
            result_o <= result_nxt;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq: directed cases plus random divides against an
// arithmetic reference model.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic        stallreq_o;
    logic        ready_o;
    logic [63:0] result_o;

    int total = 0;
    int bad   = 0;

    div_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .annul_i    (annul_i),
        .stallreq_o (stallreq_o),
        .ready_o    (ready_o),
        .result_o   (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division on wide integers, then wrap to 32 bits.
    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint q, r;
        logic [31:0] qq, rr;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'(a) / longint'(b);
            r = longint'(a) % longint'(b);
        end
        qq = q[31:0];
        rr = r[31:0];
        return {rr, qq};
    endfunction

    // One complete request: issue, wait, check, optional hold, release.
    task automatic do_div(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input int hold, output logic [63:0] res);
        int          lat;
        int          explat;
        logic [63:0] exp;
        exp    = ref_div(sg, a, b);
        explat = (b == 32'd0) ? 2 : 34;
        signed_i  = sg;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        #1;
        chk({tag, " stall_at_start"}, 64'(stallreq_o), 64'd1);
        lat = 0;
        while (ready_o !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 3) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                signed_i  = ~sg;
            end
        end
        chk({tag, " latency"}, 64'(lat), 64'(explat));
        chk({tag, " result"}, result_o, exp);
        chk({tag, " stall_at_ready"}, 64'(stallreq_o), 64'd0);
        res = result_o;
        for (int i = 0; i < hold; i++) begin
            annul_i = (i % 2 == 0);
            @(posedge clk); #1;
            chk({tag, " hold_result"}, result_o, exp);
            chk({tag, " hold_ready"}, 64'(ready_o), 64'd1);
        end
        annul_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, " release_ready"}, 64'(ready_o), 64'd0);
        chk({tag, " release_result"}, result_o, 64'd0);
    endtask

    initial begin
        logic [63:0] res;
        logic        seen;
        int          lat;
        logic        sg;
        logic [31:0] a, b;

        rst       = 1'b0;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        annul_i   = 1'b0;
        #3;
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset result", result_o, 64'd0);
        chk("reset stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases with fixed expected results.
        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 0, res);
        chk("const divu_100_7", res, 64'h00000002_0000000E);
        do_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 0, res);
        chk("const div_m7_2", res, 64'hFFFFFFFF_FFFFFFFD);
        do_div("divu_ff_2", 1'b0, 32'hFFFFFFFF, 32'd2, 0, res);
        chk("const divu_ff_2", res, 64'h00000001_7FFFFFFF);
        do_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, res);
        chk("const div_min_m1", res, 64'h00000000_80000000);
        do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 0, res);
        chk("const divu_5_0", res, 64'd0);

        // Annul at iteration 10, with start still high.
        signed_i  = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        annul_i = 1'b1;
        #1;
        chk("annul stall_drop", 64'(stallreq_o), 64'd0);
        seen = 1'b0;
        // start and annul both high in FREE must not launch a divide.
        repeat (3) begin
            @(posedge clk); #1;
            if (ready_o !== 1'b0) seen = 1'b1;
        end
        annul_i = 1'b0;
        start_i = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o !== 1'b0) seen = 1'b1;
        end
        chk("annul no_ready", 64'(seen), 64'd0);
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3, 0, res);
        chk("const divu_9_3", res, 64'h00000000_00000003);

        // Hold start_i past ready_o, then back-to-back divides.
        do_div("hold", 1'b1, 32'd1000, 32'hFFFFFFFD, 5, res);
        do_div("b2b_a", 1'b0, 32'd12345, 32'd10, 0, res);
        do_div("b2b_b", 1'b1, 32'hFFFF0000, 32'd3, 0, res);

        // Asynchronous reset between edges, mid-iteration.
        signed_i  = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_on ready", 64'(ready_o), 64'd0);
        chk("rst_on result", result_o, 64'd0);
        start_i = 1'b0;
        #2;
        rst = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o !== 1'b0 || result_o !== 64'd0) seen = 1'b1;
        end
        chk("rst_on quiet", 64'(seen), 64'd0);
        do_div("after_rst", 1'b0, 32'd77, 32'd5, 0, res);

        // Asynchronous reset while a result is presented.
        signed_i  = 1'b0;
        opdata1_i = 32'd50;
        opdata2_i = 32'd6;
        start_i   = 1'b1;
        lat = 0;
        while (ready_o !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("rst_end ready_before", 64'(ready_o), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_end ready", 64'(ready_o), 64'd0);
        chk("rst_end result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Random divides against the reference model.
        for (int n = 0; n < 24; n++) begin
            sg = 1'($urandom % 2);
            a  = $urandom;
            if (n % 7 == 0) a = 32'h80000000;
            case ($urandom % 6)
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFFFFFF;
                3:       b = $urandom % 16;
                default: b = $urandom;
            endcase
            do_div($sformatf("rand%0d", n), sg, a, b, int'($urandom % 3), res);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
